bc_control_unit: RTL and testbench

//  Timing/control sequencer for the basic computer. Watches the 4-bit sequence counter and IR.

---
 rtl/bc_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_bc_control_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bc_control_unit.sv
// Timing/control sequencer for the basic computer: decodes (sequence, R, I, IR) into strobes.
// Define BC_INTERRUPT_EN to build the interrupt cycle and the I/O instruction group.
module bc_control_unit #(
  parameter int unsigned TLimit = 7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  sequence_i,
  input  logic [15:0] ir_i,
  input  logic        ac_msb_i,
  input  logic        ac_zero_i,
  input  logic        dr_zero_i,
  input  logic        e_bit_i,
  input  logic        fgi_i,
  input  logic        fgo_i,
  output logic        sc_inc_o,
  output logic        sc_clr_o,
  output logic        ar_ld_o,
  output logic        ar_inc_o,
  output logic        ar_clr_o,
  output logic        pc_ld_o,
  output logic        pc_inc_o,
  output logic        pc_clr_o,
  output logic        dr_ld_o,
  output logic        dr_inc_o,
  output logic        ac_ld_o,
  output logic        ac_inc_o,
  output logic        ac_clr_o,
  output logic        ir_ld_o,
  output logic        tr_ld_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [2:0]  bus_sel_o,
  output logic [2:0]  alu_op_o,
  output logic        e_clr_o,
  output logic        e_cmp_o,
  output logic        fgi_clr_o,
  output logic        fgo_clr_o,
  output logic        s_flag_o,
  output logic        r_flag_o,
  output logic        ien_o,
  output logic        err_o
);

  localparam logic [2:0] BusNone = 3'd0;
  localparam logic [2:0] BusAr   = 3'd1;
  localparam logic [2:0] BusPc   = 3'd2;
  localparam logic [2:0] BusDr   = 3'd3;
  localparam logic [2:0] BusAc   = 3'd4;
  localparam logic [2:0] BusIr   = 3'd5;
  localparam logic [2:0] BusMem  = 3'd7;
  localparam logic [2:0] AluAnd  = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluDr   = 3'd2;
  localparam logic [2:0] AluCma  = 3'd4;
  localparam logic [2:0] AluCir  = 3'd5;
  localparam logic [2:0] AluCil  = 3'd6;
  localparam logic [2:0] OpIo    = 3'd7;
  localparam logic [4:0] TLim    = 5'(TLimit);
`ifdef BC_INTERRUPT_EN
  localparam logic [2:0] BusTr   = 3'd6;
  localparam logic [2:0] AluInpr = 3'd3;
`endif

  logic        s_q, s_d;
  logic        i_q, i_d;
  logic        err_q, err_d;
  logic        r_q, ien_q;
`ifdef BC_INTERRUPT_EN
  logic        r_d, ien_d;
`endif
  logic        run;
  logic        guard;
  logic [2:0]  op;
  logic [11:0] ib;

  assign op    = ir_i[14:12];
  assign ib    = ir_i[11:0];
  // Reset overrides the run flag combinationally so the counter is held clear during reset.
  assign run   = s_q & ~reset_i;
  assign guard = {1'b0, sequence_i} >= TLim;

  always_comb begin
    sc_clr_o    = 1'b0;
    ar_ld_o     = 1'b0;
    ar_inc_o    = 1'b0;
    ar_clr_o    = 1'b0;
    pc_ld_o     = 1'b0;
    pc_inc_o    = 1'b0;
    pc_clr_o    = 1'b0;
    dr_ld_o     = 1'b0;
    dr_inc_o    = 1'b0;
    ac_ld_o     = 1'b0;
    ac_inc_o    = 1'b0;
    ac_clr_o    = 1'b0;
    ir_ld_o     = 1'b0;
    tr_ld_o     = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    bus_sel_o   = BusNone;
    alu_op_o    = AluAnd;
    e_clr_o     = 1'b0;
    e_cmp_o     = 1'b0;
    s_d         = s_q;
    i_d         = i_q;
    err_d       = err_q;
`ifdef BC_INTERRUPT_EN
    fgi_clr_o   = 1'b0;
    fgo_clr_o   = 1'b0;
    r_d         = r_q;
    ien_d       = ien_q;
`endif
    if (start_i) s_d = 1'b1;

    if (!run) begin
      sc_clr_o = 1'b1;
    end else if (guard) begin
      sc_clr_o = 1'b1;
      err_d    = 1'b1;
`ifdef BC_INTERRUPT_EN
    end else if (r_q) begin
      case (sequence_i)
        4'd0: begin
          ar_clr_o  = 1'b1;
          tr_ld_o   = 1'b1;
          bus_sel_o = BusPc;
        end
        4'd1: begin
          mem_write_o = 1'b1;
          pc_clr_o    = 1'b1;
          bus_sel_o   = BusTr;
        end
        4'd2: begin
          pc_inc_o = 1'b1;
          sc_clr_o = 1'b1;
          ien_d    = 1'b0;
          r_d      = 1'b0;
        end
        default: ;
      endcase
`endif
    end else begin
      case (sequence_i)
        4'd0: begin
          ar_ld_o   = 1'b1;
          bus_sel_o = BusPc;
        end
        4'd1: begin
          ir_ld_o    = 1'b1;
          pc_inc_o   = 1'b1;
          mem_read_o = 1'b1;
          bus_sel_o  = BusMem;
        end
        4'd2: begin
          ar_ld_o   = 1'b1;
          bus_sel_o = BusIr;
          i_d       = ir_i[15];
        end
        4'd3: begin
          if (op != OpIo) begin
            if (i_q) begin
              ar_ld_o    = 1'b1;
              mem_read_o = 1'b1;
              bus_sel_o  = BusMem;
            end
          end else if (!i_q) begin
            // Register-reference group: several bits may be set at once.
            sc_clr_o = 1'b1;
            ac_clr_o = ib[11];
            e_clr_o  = ib[10];
            if (ib[9]) begin
              ac_ld_o  = 1'b1;
              alu_op_o = AluCma;
            end
            e_cmp_o = ib[8];
            if (ib[7]) begin
              ac_ld_o  = 1'b1;
              alu_op_o = AluCir;
            end
            if (ib[6]) begin
              ac_ld_o  = 1'b1;
              alu_op_o = AluCil;
            end
            ac_inc_o = ib[5];
            pc_inc_o = (ib[4] & ~ac_msb_i) | (ib[3] & ac_msb_i) |
                       (ib[2] & ac_zero_i) | (ib[1] & ~e_bit_i);
            if (ib[0]) s_d = 1'b0;
          end else begin
            sc_clr_o = 1'b1;
`ifdef BC_INTERRUPT_EN
            if (ib[11]) begin
              ac_ld_o   = 1'b1;
              alu_op_o  = AluInpr;
              fgi_clr_o = 1'b1;
            end
            fgo_clr_o = ib[10];
            pc_inc_o  = (ib[9] & fgi_i) | (ib[8] & fgo_i);
            if (ib[7]) ien_d = 1'b1;
            if (ib[6]) ien_d = 1'b0;
`endif
          end
        end
        4'd4: begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              dr_ld_o    = 1'b1;
              mem_read_o = 1'b1;
              bus_sel_o  = BusMem;
            end
            3'd3: begin
              mem_write_o = 1'b1;
              bus_sel_o   = BusAc;
              sc_clr_o    = 1'b1;
            end
            3'd4: begin
              pc_ld_o   = 1'b1;
              bus_sel_o = BusAr;
              sc_clr_o  = 1'b1;
            end
            3'd5: begin
              mem_write_o = 1'b1;
              ar_inc_o    = 1'b1;
              bus_sel_o   = BusPc;
            end
            default: ;
          endcase
        end
        4'd5: begin
          case (op)
            3'd0: begin
              ac_ld_o  = 1'b1;
              alu_op_o = AluAnd;
              sc_clr_o = 1'b1;
            end
            3'd1: begin
              ac_ld_o  = 1'b1;
              alu_op_o = AluAdd;
              sc_clr_o = 1'b1;
            end
            3'd2: begin
              ac_ld_o  = 1'b1;
              alu_op_o = AluDr;
              sc_clr_o = 1'b1;
            end
            3'd5: begin
              pc_ld_o   = 1'b1;
              bus_sel_o = BusAr;
              sc_clr_o  = 1'b1;
            end
            3'd6: dr_inc_o = 1'b1;
            default: ;
          endcase
        end
        4'd6: begin
          if (op == 3'd6) begin
            mem_write_o = 1'b1;
            bus_sel_o   = BusDr;
            pc_inc_o    = dr_zero_i;
            sc_clr_o    = 1'b1;
          end
        end
        default: ;
      endcase
    end

`ifdef BC_INTERRUPT_EN
    // Interrupt request is only latched outside the fetch window T0..T2.
    if (run && (sequence_i > 4'd2) && ien_q && (fgi_i || fgo_i)) r_d = 1'b1;
`endif
  end

  assign sc_inc_o = run & ~sc_clr_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_q   <= 1'b0;
      i_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      i_q   <= i_d;
      err_q <= err_d;
    end
  end

`ifdef BC_INTERRUPT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_q   <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      ien_q <= ien_d;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = fgi_i ^ fgo_i;
  assign r_q       = 1'b0;
  assign ien_q     = 1'b0;
  assign fgi_clr_o = 1'b0;
  assign fgo_clr_o = 1'b0;
`endif

  assign s_flag_o = s_q;
  assign r_flag_o = r_q;
  assign ien_o    = ien_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_bc_control_unit.sv
// Table-driven directed bench for bc_control_unit; interrupt sequence runs with BC_INTERRUPT_EN.
module tb_bc_control_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  seq;
  logic [15:0] ir;
  logic        ac_msb, ac_zero, dr_zero, e_bit, fgi, fgo;
  logic        sc_inc, sc_clr, ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr;
  logic        dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, mem_read, mem_write;
  logic [2:0]  bus_sel, alu_op;
  logic        e_clr, e_cmp, fgi_clr, fgo_clr, s_flag, r_flag, ien, err;
  logic [30:0] act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bc_control_unit dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sequence_i(seq), .ir_i(ir),
    .ac_msb_i(ac_msb), .ac_zero_i(ac_zero), .dr_zero_i(dr_zero), .e_bit_i(e_bit),
    .fgi_i(fgi), .fgo_i(fgo), .sc_inc_o(sc_inc), .sc_clr_o(sc_clr),
    .ar_ld_o(ar_ld), .ar_inc_o(ar_inc), .ar_clr_o(ar_clr), .pc_ld_o(pc_ld),
    .pc_inc_o(pc_inc), .pc_clr_o(pc_clr), .dr_ld_o(dr_ld), .dr_inc_o(dr_inc),
    .ac_ld_o(ac_ld), .ac_inc_o(ac_inc), .ac_clr_o(ac_clr), .ir_ld_o(ir_ld),
    .tr_ld_o(tr_ld), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .bus_sel_o(bus_sel), .alu_op_o(alu_op), .e_clr_o(e_clr), .e_cmp_o(e_cmp),
    .fgi_clr_o(fgi_clr), .fgo_clr_o(fgo_clr), .s_flag_o(s_flag), .r_flag_o(r_flag),
    .ien_o(ien), .err_o(err)
  );

  assign act = {r_flag, ien, s_flag, err, sc_inc, sc_clr, ar_ld, ar_inc, ar_clr, pc_ld,
                pc_inc, pc_clr, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld,
                mem_read, mem_write, bus_sel, alu_op, e_clr, e_cmp, fgi_clr, fgo_clr};

  localparam logic [30:0] RF     = 31'(1) << 30;
  localparam logic [30:0] IEN    = 31'(1) << 29;
  localparam logic [30:0] FS     = 31'(1) << 28;
  localparam logic [30:0] FE     = 31'(1) << 27;
  localparam logic [30:0] SI     = 31'(1) << 26;
  localparam logic [30:0] SC     = 31'(1) << 25;
  localparam logic [30:0] ARLD   = 31'(1) << 24;
  localparam logic [30:0] ARINC  = 31'(1) << 23;
  localparam logic [30:0] ARCLR  = 31'(1) << 22;
  localparam logic [30:0] PCLD   = 31'(1) << 21;
  localparam logic [30:0] PCINC  = 31'(1) << 20;
  localparam logic [30:0] PCCLR  = 31'(1) << 19;
  localparam logic [30:0] DRLD   = 31'(1) << 18;
  localparam logic [30:0] DRINC  = 31'(1) << 17;
  localparam logic [30:0] ACLD   = 31'(1) << 16;
  localparam logic [30:0] ACINC  = 31'(1) << 15;
  localparam logic [30:0] ACCLR  = 31'(1) << 14;
  localparam logic [30:0] IRLD   = 31'(1) << 13;
  localparam logic [30:0] TRLD   = 31'(1) << 12;
  localparam logic [30:0] MRD    = 31'(1) << 11;
  localparam logic [30:0] MWR    = 31'(1) << 10;
  localparam logic [30:0] ECLR   = 31'(1) << 3;
  localparam logic [30:0] ECMP   = 31'(1) << 2;
  localparam logic [30:0] FGICLR = 31'(1) << 1;

  function automatic logic [30:0] bus(input int v);
    return 31'(v) << 7;
  endfunction

  function automatic logic [30:0] alu(input int v);
    return 31'(v) << 4;
  endfunction

  // st = {ac_msb, ac_zero, dr_zero, e_bit, fgi, fgo}
  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic [3:0]  seq;
    logic [15:0] ir;
    logic [5:0]  st;
    logic [30:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic r, input logic s, input logic [3:0] q,
                     input logic [15:0] i, input logic [5:0] st, input logic [30:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.seq = q; v.ir = i; v.st = st; v.exp = e;
    tbl.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic r, input logic s, input logic [3:0] q,
                       input logic [15:0] i, input logic [5:0] st);
    @(negedge clk);
    reset = r; start = s; seq = q; ir = i;
    {ac_msb, ac_zero, dr_zero, e_bit, fgi, fgo} = st;
    #2;
  endtask

  task automatic check(input string n, input logic [30:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  task automatic check_bit(input string n, input logic got, input logic e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (seq %0d ir %h)", n, got, e, seq, ir);
    end
  endtask

  task automatic step(input string n, input logic r, input logic s, input logic [3:0] q,
                      input logic [15:0] i, input logic [5:0] st, input logic [30:0] e);
    drive(r, s, q, i, st);
    check(n, e);
  endtask

  logic [15:0] sweep_ir [7];

  initial begin
    reset = 1'b1; start = 1'b0; seq = 4'd0; ir = 16'h0000;
    {ac_msb, ac_zero, dr_zero, e_bit, fgi, fgo} = 6'b0;
    @(posedge clk);

    add("reset_idle",  1, 0, 0, 16'h0000, 6'b0, SC);
    add("reset_t3",    1, 0, 3, 16'h2005, 6'b0, SC);
    add("start_pulse", 0, 1, 0, 16'h2005, 6'b0, SC);
    add("lda_t0",      0, 0, 0, 16'h2005, 6'b0, FS | SI | ARLD | bus(2));
    add("lda_t1",      0, 0, 1, 16'h2005, 6'b0, FS | SI | IRLD | PCINC | MRD | bus(7));
    add("lda_t2",      0, 0, 2, 16'h2005, 6'b0, FS | SI | ARLD | bus(5));
    add("lda_t3_strt", 0, 1, 3, 16'h2005, 6'b0, FS | SI);
    add("lda_t4",      0, 0, 4, 16'h2005, 6'b0, FS | SI | DRLD | MRD | bus(7));
    add("lda_t5",      0, 0, 5, 16'h2005, 6'b0, FS | SC | ACLD | alu(2));
    add("addi_t2",     0, 0, 2, 16'h9123, 6'b0, FS | SI | ARLD | bus(5));
    add("addi_t3",     0, 0, 3, 16'h9123, 6'b0, FS | SI | ARLD | MRD | bus(7));
    add("addi_t4",     0, 0, 4, 16'h9123, 6'b0, FS | SI | DRLD | MRD | bus(7));
    add("addi_t5",     0, 0, 5, 16'h9123, 6'b0, FS | SC | ACLD | alu(1));
    add("and_t2",      0, 0, 2, 16'h0456, 6'b0, FS | SI | ARLD | bus(5));
    add("and_t3",      0, 0, 3, 16'h0456, 6'b0, FS | SI);
    add("and_t5",      0, 0, 5, 16'h0456, 6'b0, FS | SC | ACLD);
    add("sta_t2",      0, 0, 2, 16'h3010, 6'b0, FS | SI | ARLD | bus(5));
    add("sta_t4",      0, 0, 4, 16'h3010, 6'b0, FS | SC | MWR | bus(4));
    add("bun_t4",      0, 0, 4, 16'h4020, 6'b0, FS | SC | PCLD | bus(1));
    add("bsa_t4",      0, 0, 4, 16'h5030, 6'b0, FS | SI | MWR | ARINC | bus(2));
    add("bsa_t5",      0, 0, 5, 16'h5030, 6'b0, FS | SC | PCLD | bus(1));
    add("isz_t4",      0, 0, 4, 16'h6010, 6'b0, FS | SI | DRLD | MRD | bus(7));
    add("isz_t5",      0, 0, 5, 16'h6010, 6'b0, FS | SI | DRINC);
    add("isz_t6_zero", 0, 0, 6, 16'h6010, 6'b001000, FS | SC | MWR | bus(3) | PCINC);
    add("isz_t6_nz",   0, 0, 6, 16'h6010, 6'b0, FS | SC | MWR | bus(3));
    add("rr_t2",       0, 0, 2, 16'h7800, 6'b0, FS | SI | ARLD | bus(5));
    add("cla",         0, 0, 3, 16'h7800, 6'b0, FS | SC | ACCLR);
    add("cle",         0, 0, 3, 16'h7400, 6'b0, FS | SC | ECLR);
    add("cma",         0, 0, 3, 16'h7200, 6'b0, FS | SC | ACLD | alu(4));
    add("cme",         0, 0, 3, 16'h7100, 6'b0, FS | SC | ECMP);
    add("cir",         0, 0, 3, 16'h7080, 6'b0, FS | SC | ACLD | alu(5));
    add("cil",         0, 0, 3, 16'h7040, 6'b0, FS | SC | ACLD | alu(6));
    add("inc",         0, 0, 3, 16'h7020, 6'b0, FS | SC | ACINC);
    add("spa_take",    0, 0, 3, 16'h7010, 6'b0, FS | SC | PCINC);
    add("spa_skip",    0, 0, 3, 16'h7010, 6'b100000, FS | SC);
    add("sna_take",    0, 0, 3, 16'h7008, 6'b100000, FS | SC | PCINC);
    add("sna_skip",    0, 0, 3, 16'h7008, 6'b0, FS | SC);
    add("sza_take",    0, 0, 3, 16'h7004, 6'b010000, FS | SC | PCINC);
    add("sze_take",    0, 0, 3, 16'h7002, 6'b0, FS | SC | PCINC);
    add("sze_skip",    0, 0, 3, 16'h7002, 6'b000100, FS | SC);
    add("io_t2",       0, 0, 2, 16'hF000, 6'b0, FS | SI | ARLD | bus(5));
    add("io_nop_t3",   0, 0, 3, 16'hF000, 6'b0, FS | SC);
    add("hlt_t2",      0, 0, 2, 16'h7001, 6'b0, FS | SI | ARLD | bus(5));
    add("hlt_t3_strt", 0, 1, 3, 16'h7001, 6'b0, FS | SC);
    add("halted",      0, 0, 0, 16'h7001, 6'b0, SC);
    add("restart",     0, 1, 0, 16'h2005, 6'b0, SC);
    add("resume_t0",   0, 0, 0, 16'h2005, 6'b0, FS | SI | ARLD | bus(2));
    add("guard_t7",    0, 0, 7, 16'h2005, 6'b0, FS | SC);
    add("err_sticky",  0, 0, 0, 16'h2005, 6'b0, FS | FE | SI | ARLD | bus(2));
    add("reset_mid",   1, 0, 4, 16'h2005, 6'b0, FS | FE | SC);
    add("after_reset", 0, 0, 4, 16'h2005, 6'b0, SC);
    add("start2",      0, 1, 0, 16'h2005, 6'b0, SC);
    add("run_t0",      0, 0, 0, 16'h2005, 6'b0, FS | SI | ARLD | bus(2));
    add("guard_t9",    0, 0, 9, 16'h2005, 6'b0, FS | SC);
    add("err_t0",      0, 0, 0, 16'h2005, 6'b0, FS | FE | SI | ARLD | bus(2));

    foreach (tbl[k]) step(tbl[k].name, tbl[k].rst, tbl[k].start, tbl[k].seq, tbl[k].ir,
                          tbl[k].st, tbl[k].exp);

    // Exclusivity sweep over every T-state for a spread of instructions.
    sweep_ir = '{16'h2005, 16'h9123, 16'h3010, 16'h4020, 16'h5030, 16'h6010, 16'hF000};
    drive(1, 0, 0, 16'h0000, 6'b0);
    drive(0, 1, 0, 16'h0000, 6'b0);
    foreach (sweep_ir[n]) begin
      for (int q = 0; q < 16; q++) begin
        drive(0, 0, 4'(q), sweep_ir[n], 6'b111111);
        check_bit("sweep_run", s_flag, 1'b1);
        check_bit("sc_excl", sc_inc & sc_clr, 1'b0);
        check_bit("mem_excl", mem_read & mem_write, 1'b0);
      end
    end

`ifdef BC_INTERRUPT_EN
    drive(1, 0, 0, 16'h0000, 6'b0);
    step("i_start",   0, 1, 0, 16'hF080, 6'b0, SC);
    step("ion_t2",    0, 0, 2, 16'hF080, 6'b0, FS | SI | ARLD | bus(5));
    step("ion_t3",    0, 0, 3, 16'hF080, 6'b0, FS | SC);
    step("nop_t2",    0, 0, 2, 16'h7000, 6'b0, FS | IEN | SI | ARLD | bus(5));
    step("nop_t3fgi", 0, 0, 3, 16'h7000, 6'b000010, FS | IEN | SC);
    step("rt0",       0, 0, 0, 16'h7000, 6'b000010, RF | IEN | FS | SI | ARCLR | TRLD | bus(2));
    step("rt1",       0, 0, 1, 16'h7000, 6'b000010, RF | IEN | FS | SI | MWR | PCCLR | bus(6));
    step("rt2",       0, 0, 2, 16'h7000, 6'b000010, RF | IEN | FS | SC | PCINC);
    step("post_int",  0, 0, 0, 16'h7000, 6'b000010, FS | SI | ARLD | bus(2));
    step("ski_t2",    0, 0, 2, 16'hF200, 6'b0, FS | SI | ARLD | bus(5));
    step("ski_take",  0, 0, 3, 16'hF200, 6'b000010, FS | SC | PCINC);
    step("inp",       0, 0, 3, 16'hF800, 6'b0, FS | SC | ACLD | alu(3) | FGICLR);
    step("out",       0, 0, 3, 16'hF400, 6'b0, FS | SC | 31'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
